mux4_1: RTL and testbench

// - Registered 4-to-1 multiplexer: selects one of four data inputs by a 2-bit select
//   and presents it on a single registered output.
// - Generic datapath primitive used wherever four candidate sources feed one sink.
// - Output is captured on the rising clock edge, giving a glitch-free result one cycle

---
 rtl/mux_pkg.sv | 18 +
 rtl/mux4_1_comb.sv | 36 +++
 rtl/mux4_1.sv | 52 +++++
 tb/tb_mux4_1.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// ----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the multiplexer primitives.
//
// Contents:
//   sel_t            2-bit source select type
//   SEL_IN0..SEL_IN3 select codes for in0..in3
// ----------------------------------------------------------------------------
package mux_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_IN0 = 2'd0;
    localparam sel_t SEL_IN1 = 2'd1;
    localparam sel_t SEL_IN2 = 2'd2;
    localparam sel_t SEL_IN3 = 2'd3;

endpackage : mux_pkg

// File: rtl/mux4_1_comb.sv
// ----------------------------------------------------------------------------
// mux4_1_comb
// Purely combinational WIDTH-bit 4:1 selector.
//
// Ports:
//   in0..in3  input   WIDTH  candidate data sources
//   sel       input   2      source select (SEL_IN0..SEL_IN3)
//   y         output  WIDTH  selected data, zero for any undecodable select
// ----------------------------------------------------------------------------
module mux4_1_comb
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  sel_t             sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        // NOTE: default assignment first so every path drives y and no latch is inferred.
        y = '0;
        case (sel)
            SEL_IN0: y = in0;
            SEL_IN1: y = in1;
            SEL_IN2: y = in2;
            SEL_IN3: y = in3;
            // An X/Z select matches none of the codes above and yields zero.
            default: y = '0;
        endcase
    end

endmodule : mux4_1_comb

// File: rtl/mux4_1.sv
// ----------------------------------------------------------------------------
// mux4_1
// Registered 4-to-1 multiplexer. The selected source appears on out one clock
// after sel and the inputs settle; out holds between edges.
//
// Ports:
//   clk       input   1      rising-edge clock
//   rst_n     input   1      synchronous reset, active-low; clears out
//   in0..in3  input   WIDTH  data sources for sel = 00 / 01 / 10 / 11
//   sel       input   2      source select
//   out       output  WIDTH  registered selected data
// ----------------------------------------------------------------------------
module mux4_1
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  sel_t             sel,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] sel_data;

    mux4_1_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .in0 (in0),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .sel (sel),
        .y   (sel_data)
    );

    // Reset is only looked at on the clock edge, so rst_n has no
    // combinational path to out and takes priority over capture.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for registered state avoids simulation races.
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= sel_data;
        end
    end

endmodule : mux4_1

// File: tb/tb_mux4_1.sv
// ----------------------------------------------------------------------------
// tb_mux4_1
// Directed test of mux4_1 with a 1-bit instance and an 8-bit instance.
// ----------------------------------------------------------------------------
module tb_mux4_1;

    logic       clk;
    int         total;
    int         bad;

    // 1-bit instance
    logic       a_rst_n;
    logic       a_in0, a_in1, a_in2, a_in3;
    logic [1:0] a_sel;
    logic       a_out;

    // 8-bit instance
    logic       b_rst_n;
    logic [7:0] b_in0, b_in1, b_in2, b_in3;
    logic [1:0] b_sel;
    logic [7:0] b_out;

    mux4_1 #(.WIDTH(1)) dut_a (
        .clk   (clk),
        .rst_n (a_rst_n),
        .in0   (a_in0),
        .in1   (a_in1),
        .in2   (a_in2),
        .in3   (a_in3),
        .sel   (a_sel),
        .out   (a_out)
    );

    mux4_1 #(.WIDTH(8)) dut_b (
        .clk   (clk),
        .rst_n (b_rst_n),
        .in0   (b_in0),
        .in1   (b_in1),
        .in2   (b_in2),
        .in3   (b_in3),
        .sel   (b_sel),
        .out   (b_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0;
        a_in0 = 1'b1; a_in1 = 1'b1; a_in2 = 1'b1; a_in3 = 1'b1;
        a_sel = 2'b00;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (a_out !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold[%0d]: got %0h want 0", i, a_out);
            end
        end
        a_rst_n = 1'b1;
        step();
        total++;
        if (a_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: got %0h want 1", a_out);
        end
    endtask

    task automatic test_sel_in0();
        a_in0 = 1'b1; a_in1 = 1'b0; a_in2 = 1'b0; a_in3 = 1'b0;
        a_sel = 2'b00;
        step();
        total++;
        if (a_out !== 1'b1) begin
            bad++;
            $display("FAIL sel_in0: got %0h want 1", a_out);
        end
        a_in0 = 1'b0; a_in1 = 1'b1;
        a_sel = 2'b01;
        step();
        total++;
        if (a_out !== 1'b1) begin
            bad++;
            $display("FAIL sel_in1: got %0h want 1", a_out);
        end
    endtask

    task automatic test_sel_in2();
        a_in0 = 1'b1; a_in1 = 1'b1; a_in2 = 1'b0; a_in3 = 1'b1;
        a_sel = 2'b10;
        step();
        total++;
        if (a_out !== 1'b0) begin
            bad++;
            $display("FAIL sel_in2: got %0h want 0", a_out);
        end
        // Toggle every non-selected input; out must stay 0.
        for (int i = 0; i < 3; i++) begin
            a_in0 = ~a_in0; a_in1 = ~a_in1; a_in3 = ~a_in3;
            step();
            total++;
            if (a_out !== 1'b0) begin
                bad++;
                $display("FAIL sel_in2_toggle[%0d]: got %0h want 0", i, a_out);
            end
        end
    endtask

    task automatic test_sel_in3();
        a_in0 = 1'b0; a_in1 = 1'b0; a_in2 = 1'b0; a_in3 = 1'b1;
        a_sel = 2'b11;
        step();
        total++;
        if (a_out !== 1'b1) begin
            bad++;
            $display("FAIL sel_in3: got %0h want 1", a_out);
        end
        a_in3 = 1'b0;
        step();
        total++;
        if (a_out !== 1'b0) begin
            bad++;
            $display("FAIL sel_in3_clear: got %0h want 0", a_out);
        end
    endtask

    task automatic test_latency();
        a_in0 = 1'b1; a_in1 = 1'b0; a_in2 = 1'b0; a_in3 = 1'b0;
        a_sel = 2'b00;
        step();
        total++;
        if (a_out !== 1'b1) begin
            bad++;
            $display("FAIL latency_setup: got %0h want 1", a_out);
        end
        // Change sel mid-cycle; out must not move until the next edge.
        #2;
        a_sel = 2'b01;
        #2;
        total++;
        if (a_out !== 1'b1) begin
            bad++;
            $display("FAIL latency_midcycle: got %0h want 1", a_out);
        end
        step();
        total++;
        if (a_out !== 1'b0) begin
            bad++;
            $display("FAIL latency_after_edge: got %0h want 0", a_out);
        end
    endtask

    task automatic test_wide_mid_reset();
        logic [7:0] exp_tbl [4];
        exp_tbl[0] = 8'hA5; exp_tbl[1] = 8'h3C; exp_tbl[2] = 8'hFF; exp_tbl[3] = 8'h01;
        b_in0 = 8'hA5; b_in1 = 8'h3C; b_in2 = 8'hFF; b_in3 = 8'h01;
        b_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_sel = 2'(i);
            step();
            total++;
            if (b_out !== exp_tbl[i]) begin
                bad++;
                $display("FAIL wide_sweep[%0d]: got %02h want %02h", i, b_out, exp_tbl[i]);
            end
        end
        // Reset pulse with sel = 10 held so the resume value is FF.
        b_sel = 2'b10;
        b_rst_n = 1'b0;
        step();
        total++;
        if (b_out !== 8'h00) begin
            bad++;
            $display("FAIL wide_reset: got %02h want 00", b_out);
        end
        b_rst_n = 1'b1;
        step();
        total++;
        if (b_out !== 8'hFF) begin
            bad++;
            $display("FAIL wide_resume: got %02h want ff", b_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_v;
        b_in0 = 8'h11; b_in1 = 8'h22; b_in2 = 8'h44; b_in3 = 8'h88;
        for (int i = 3; i >= 0; i--) begin
            b_sel = 2'(i);
            step();
            case (i)
                0:       exp_v = 8'h11;
                1:       exp_v = 8'h22;
                2:       exp_v = 8'h44;
                default: exp_v = 8'h88;
            endcase
            total++;
            if (b_out !== exp_v) begin
                bad++;
                $display("FAIL back_to_back[%0d]: got %02h want %02h", i, b_out, exp_v);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        b_rst_n = 1'b0;
        b_in0 = '0; b_in1 = '0; b_in2 = '0; b_in3 = '0;
        b_sel = 2'b00;

        test_reset();
        test_sel_in0();
        test_sel_in2();
        test_sel_in3();
        test_latency();
        test_wide_mid_reset();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mux4_1
